turfio_bank_seq: RTL



---
 rtl/turfio_bank_seq.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/turfio_bank_seq.sv
// TURFIO bank-control hub: WISHBONE decode/fan-out to NUM_IF slaves, plus a
// per-bank MMCM -> IDELAYCTRL -> ISERDES/IDELAY reset sequencer with timeouts.
module turfio_bank_seq #(
    parameter int NUM_BANKS      = 2,
    parameter int NUM_IF         = 4,
    parameter int IF_ADR_BITS    = 12,
    parameter int PULSE_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int AUTO_START     = 1,
    parameter int AUTO_RESTART   = 0,
    localparam int IDX_W         = $clog2(NUM_IF),
    localparam int ADR_BITS      = IF_ADR_BITS + IDX_W + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_we_i,
    input  logic [ADR_BITS-1:0]      wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_rty_o,
    output logic [NUM_IF-1:0]        m_cyc_o,
    output logic                     m_stb_o,
    output logic                     m_we_o,
    output logic [IF_ADR_BITS-1:0]   m_adr_o,
    output logic [31:0]              m_dat_o,
    output logic [3:0]               m_sel_o,
    input  logic [32*NUM_IF-1:0]     m_dat_i,
    input  logic [NUM_IF-1:0]        m_ack_i,
    input  logic [NUM_IF-1:0]        m_err_i,
    input  logic [NUM_IF-1:0]        m_rty_i,
    input  logic [NUM_BANKS-1:0]     mmcm_locked_i,
    input  logic [NUM_BANKS-1:0]     idelayctrl_rdy_i,
    output logic [NUM_BANKS-1:0]     mmcm_rst_o,
    output logic [NUM_BANKS-1:0]     idelayctrl_rst_o,
    output logic [NUM_BANKS-1:0]     bank_rst_o
);
    localparam int MAX_CNT = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MMCM_RST  = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_IDC_RST   = 3'd3,
        S_WAIT_RDY  = 3'd4,
        S_SETTLE    = 3'd5,
        S_READY     = 3'd6,
        S_FAULT     = 3'd7
    } seq_state_e;

    logic                   remote_sel, local_acc, local_wr;
    logic [IDX_W-1:0]       slave_idx;
    logic [1:0]             reg_idx;
    logic [31:0]            m_dat_arr [NUM_IF];
    logic                   ack_q, ack_d, auto_done_q, auto_done_d;
    logic [31:0]            rdata_q, rdata_d, reg_rd;
    logic [NUM_BANKS-1:0]   ctrl_mmcm_q, ctrl_mmcm_d, ctrl_idc_q, ctrl_idc_d, ctrl_bank_q, ctrl_bank_d;
    logic [NUM_BANKS-1:0]   seq_start, clr_lost, clr_fault;
    logic [NUM_BANKS-1:0]   lock_sync, rdy_sync, lock_lost, fault;
    logic [NUM_BANKS-1:0]   seq_mmcm, seq_idc, seq_brst;
    logic [3*NUM_BANKS-1:0] bank_state;

    assign remote_sel = wb_adr_i[ADR_BITS-1];
    assign slave_idx  = wb_adr_i[ADR_BITS-2 -: IDX_W];
    assign reg_idx    = wb_adr_i[1:0];
    assign local_acc  = wb_cyc_i & wb_stb_i & ~remote_sel & ~ack_q;
    assign local_wr   = local_acc & wb_we_i;

    assign m_stb_o = wb_stb_i;
    assign m_we_o  = wb_we_i;
    assign m_adr_o = wb_adr_i[IF_ADR_BITS-1:0];
    assign m_dat_o = wb_dat_i;
    assign m_sel_o = wb_sel_i;

    for (genvar gi = 0; gi < NUM_IF; gi++) begin : g_slave
        assign m_dat_arr[gi] = m_dat_i[32*gi +: 32];
    end

    always_comb begin
        m_cyc_o = '0;
        if (remote_sel) m_cyc_o[slave_idx] = wb_cyc_i;
    end

    assign wb_dat_o = remote_sel ? m_dat_arr[slave_idx] : rdata_q;
    assign wb_ack_o = remote_sel ? m_ack_i[slave_idx] : (ack_q & wb_cyc_i);
    assign wb_err_o = remote_sel & m_err_i[slave_idx];
    assign wb_rty_o = remote_sel & m_rty_i[slave_idx];

    always_comb begin
        reg_rd = '0;
        case (reg_idx)
            2'd0: begin
                reg_rd[0 +: NUM_BANKS]  = ctrl_mmcm_q;
                reg_rd[8 +: NUM_BANKS]  = ctrl_idc_q;
                reg_rd[16 +: NUM_BANKS] = ctrl_bank_q;
            end
            2'd1: for (int b = 0; b < NUM_BANKS; b++) reg_rd[4*b +: 3] = bank_state[3*b +: 3];
            2'd2: begin
                reg_rd[0 +: NUM_BANKS]  = lock_sync;
                reg_rd[8 +: NUM_BANKS]  = rdy_sync;
                reg_rd[16 +: NUM_BANKS] = lock_lost;
                reg_rd[24 +: NUM_BANKS] = fault;
            end
            default: reg_rd = {8'(NUM_BANKS), 8'(NUM_IF), 16'h0B51};
        endcase
    end

    // Side effects of local writes land on the same edge that raises ack.
    always_comb begin
        ctrl_mmcm_d = ctrl_mmcm_q;
        ctrl_idc_d  = ctrl_idc_q;
        ctrl_bank_d = ctrl_bank_q;
        seq_start   = '0;
        clr_lost    = '0;
        clr_fault   = '0;
        ack_d       = local_acc;
        rdata_d     = local_acc ? reg_rd : rdata_q;
        auto_done_d = 1'b1;
        if (AUTO_START != 0 && !auto_done_q) seq_start = '1;
        if (local_wr) begin
            case (reg_idx)
                2'd0: begin
                    if (wb_sel_i[0]) ctrl_mmcm_d = wb_dat_i[0 +: NUM_BANKS];
                    if (wb_sel_i[1]) ctrl_idc_d  = wb_dat_i[8 +: NUM_BANKS];
                    if (wb_sel_i[2]) ctrl_bank_d = wb_dat_i[16 +: NUM_BANKS];
                end
                2'd1: if (wb_sel_i[0]) seq_start = seq_start | wb_dat_i[0 +: NUM_BANKS];
                2'd2: begin
                    if (wb_sel_i[2]) clr_lost  = wb_dat_i[16 +: NUM_BANKS];
                    if (wb_sel_i[3]) clr_fault = wb_dat_i[24 +: NUM_BANKS];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q       <= 1'b0;
            auto_done_q <= 1'b0;
            rdata_q     <= '0;
            ctrl_mmcm_q <= '0;
            ctrl_idc_q  <= '0;
            ctrl_bank_q <= '0;
        end else begin
            ack_q       <= ack_d;
            auto_done_q <= auto_done_d;
            rdata_q     <= rdata_d;
            ctrl_mmcm_q <= ctrl_mmcm_d;
            ctrl_idc_q  <= ctrl_idc_d;
            ctrl_bank_q <= ctrl_bank_d;
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [1:0]  lock_sync_q, rdy_sync_q;
        seq_state_e  state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic        lost_q, lost_d, fault_q, fault_d;
        logic        mmcm_q, mmcm_d, idc_q, idc_d, brst_q, brst_d;
        logic        locked, ready, cnt_zero;

        assign locked   = lock_sync_q[1];
        assign ready    = rdy_sync_q[1];
        assign cnt_zero = (cnt_q == '0);

        // A start overrides everything, including a timeout on the same edge.
        always_comb begin
            state_d = state_q;
            lost_d  = lost_q & ~clr_lost[gi];
            fault_d = fault_q & ~clr_fault[gi];
            if (seq_start[gi]) begin
                state_d = S_MMCM_RST;
            end else begin
                case (state_q)
                    S_MMCM_RST:  if (cnt_zero) state_d = S_WAIT_LOCK;
                    S_WAIT_LOCK: begin
                        if (locked) state_d = S_IDC_RST;
                        else if (cnt_zero) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end
                    end
                    S_IDC_RST:   if (cnt_zero) state_d = S_WAIT_RDY;
                    S_WAIT_RDY: begin
                        if (!locked) state_d = S_MMCM_RST;
                        else if (ready) state_d = S_SETTLE;
                        else if (cnt_zero) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (!locked) state_d = S_MMCM_RST;
                        else if (cnt_zero) state_d = S_READY;
                    end
                    S_READY: begin
                        if (!locked) begin
                            lost_d = 1'b1;
                            if (AUTO_RESTART != 0) state_d = S_MMCM_RST;
                        end
                    end
                    default: ;
                endcase
            end

            if (seq_start[gi] || state_d != state_q) begin
                case (state_d)
                    S_MMCM_RST, S_IDC_RST, S_SETTLE: cnt_d = PULSE_LOAD;
                    S_WAIT_LOCK, S_WAIT_RDY:         cnt_d = TIMEOUT_LOAD;
                    default:                         cnt_d = '0;
                endcase
            end else begin
                cnt_d = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
            end

            mmcm_d = (state_q == S_MMCM_RST);
            idc_d  = (state_q == S_IDC_RST);
            brst_d = !(state_q inside {S_IDLE, S_READY});
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                lock_sync_q <= '0;
                rdy_sync_q  <= '0;
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                lost_q      <= 1'b0;
                fault_q     <= 1'b0;
                mmcm_q      <= 1'b0;
                idc_q       <= 1'b0;
                brst_q      <= 1'b0;
            end else begin
                lock_sync_q <= {lock_sync_q[0], mmcm_locked_i[gi]};
                rdy_sync_q  <= {rdy_sync_q[0], idelayctrl_rdy_i[gi]};
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                lost_q      <= lost_d;
                fault_q     <= fault_d;
                mmcm_q      <= mmcm_d;
                idc_q       <= idc_d;
                brst_q      <= brst_d;
            end
        end

        assign bank_state[3*gi +: 3] = state_q;
        assign lock_sync[gi] = locked;
        assign rdy_sync[gi]  = ready;
        assign lock_lost[gi] = lost_q;
        assign fault[gi]     = fault_q;
        assign seq_mmcm[gi]  = mmcm_q;
        assign seq_idc[gi]   = idc_q;
        assign seq_brst[gi]  = brst_q;
    end

    assign mmcm_rst_o       = ctrl_mmcm_q | seq_mmcm;
    assign idelayctrl_rst_o = ctrl_idc_q | seq_idc;
    assign bank_rst_o       = ctrl_bank_q | seq_brst;
endmodule
